// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM slave: single-port word memory with byte lanes, optional
// data-phase wait states, two-cycle ERROR responses and write-first read forwarding.
module ahb3lite_sram_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  state_t        cap_state;
  logic [2:0]    wait_cnt;
  logic [AW-1:0] d_idx;
  logic [3:0]    d_be;
  logic          d_write;

  logic [31:0]   mem [MEM_WORDS];

  logic          accept;
  logic          capture;
  logic          illegal;
  logic          out_of_range;
  logic [3:0]    a_be;
  logic [AW-1:0] a_idx;
  logic          wr_commit;
  logic [31:0]   wr_word;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_merged;
  logic          load_rd;

  // Handshake: an address phase is accepted when HSEL, HTRANS[1] and HREADY are
  // all high while this slave is not mid data phase; a data phase completes on
  // the cycle HREADYOUT is high, which is when writes commit and reads present.
  assign accept    = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign capture   = accept && HSEL && HREADY && HTRANS[1];
  assign a_idx     = HADDR[AW+1:2];
  assign dbg_state = state;

  assign out_of_range = |HADDR[31:AW+2];
  assign illegal = (HSIZE > 3'd2)
                || ((HSIZE == 3'd1) && HADDR[0])
                || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                || out_of_range;

  always_comb begin
    a_be = 4'b0000;
    case (HSIZE)
      3'd0:    a_be = 4'b0001 << HADDR[1:0];
      3'd1:    a_be = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    a_be = 4'b1111;
      default: a_be = 4'b0000;
    endcase
  end

  always_comb begin
    cap_state = S_DATA;
    if (illegal)
      cap_state = S_ERR1;
    else if (WAIT_STATES > 0)
      cap_state = S_WAIT;
  end

  // Write data merged onto the stored word using the captured lane enables.
  assign wr_commit = (state == S_DATA) && d_write;
  always_comb begin
    wr_word = mem[d_idx];
    for (int i = 0; i < 4; i++) begin
      if (d_be[i]) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // A read finishing its waits uses its captured index; a zero-wait read uses
  // the live address, and sees a same-word write committing on this edge.
  assign rd_idx    = (state == S_WAIT) ? d_idx : a_idx;
  assign rd_word   = mem[rd_idx];
  assign rd_merged = (wr_commit && (d_idx == rd_idx)) ? wr_word : rd_word;
  assign load_rd   = (capture && !illegal && !HWRITE && (WAIT_STATES == 0))
                  || ((state == S_WAIT) && (wait_cnt <= 3'd1) && !d_write);

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (wait_cnt <= 3'd1) state_nxt = S_DATA;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = capture ? cap_state : S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      wait_cnt  <= 3'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'h0;
      d_idx     <= '0;
      d_be      <= 4'b0000;
      d_write   <= 1'b0;
    end else begin
      state     <= state_nxt;
      HREADYOUT <= !((state_nxt == S_WAIT) || (state_nxt == S_ERR1));
      HRESP     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
      if (state == S_WAIT) wait_cnt <= wait_cnt - 3'd1;
      if (capture) begin
        wait_cnt <= 3'(WAIT_STATES);
        d_idx    <= a_idx;
        d_be     <= a_be;
        d_write  <= HWRITE && !illegal;
      end
      if (load_rd) HRDATA <= rd_merged;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (wr_commit && !HRESET) mem[d_idx] <= wr_word;
  end

  logic unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0]};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: one zero-wait slave and one two-wait slave sharing the address bus.
module tb_ahb3lite_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel, sel, stall;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;

  logic [31:0] rd0, rd2;
  logic        ro0, ro2, rs0, rs2;
  logic [2:0]  st0, st2;
  logic        hready0, hready2, hsel0, hsel2;

  logic [31:0] rd_c;
  logic        ro_c, rs_c;
  logic [2:0]  st_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  assign hready0 = ro0 & ~stall;
  assign hready2 = ro2;
  assign hsel0   = hsel & ~sel;
  assign hsel2   = hsel & sel;
  assign rd_c    = sel ? rd2 : rd0;
  assign ro_c    = sel ? ro2 : ro0;
  assign rs_c    = sel ? rs2 : rs0;
  assign st_c    = sel ? st2 : st0;

  ahb3lite_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready0), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0), .dbg_state(st0)
  );

  ahb3lite_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready2), .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2), .dbg_state(st2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_ph(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [1:0] tr);
    hsel   = 1'b1;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic bus_idle();
    hsel   = 1'b1;
    htrans = T_IDLE;
    hwrite = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (!ro_c && g < 20) begin
      step();
      g++;
    end
    check(tag, {31'h0, ro_c}, 32'h1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    addr_ph(1'b1, sz, a, T_NSEQ);
    step();
    hwdata = d;
    bus_idle();
    wait_ready("wr_ready");
    step();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    addr_ph(1'b0, 3'd2, a, T_NSEQ);
    step();
    bus_idle();
    wait_ready("rd_ready");
    d = rd_c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] dat [4];
    logic [31:0] bdat [4];
    int beat, cyc, waits;

    dat[0] = 32'h1111_0001; dat[1] = 32'h2222_0002;
    dat[2] = 32'h3333_0003; dat[3] = 32'h4444_0004;
    bdat[0] = 32'hA0A0_0020; bdat[1] = 32'hA1A1_0024;
    bdat[2] = 32'hA2A2_0028; bdat[3] = 32'hA3A3_002C;

    HRESET = 1'b1; sel = 1'b0; stall = 1'b0; hsel = 1'b0; haddr = 32'h0;
    hwdata = 32'h0; htrans = T_IDLE; hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0;

    // Reset state of both instances
    step(); step();
    HRESET = 1'b0;
    check("rst_ready0", {31'h0, ro0}, 32'h1);
    check("rst_resp0", {31'h0, rs0}, 32'h0);
    check("rst_rdata0", rd0, 32'h0);
    check("rst_ready2", {31'h0, ro2}, 32'h1);
    check("rst_rdata2", rd2, 32'h0);
    check("rst_state2", {29'h0, st2}, 32'h0);

    // Zero-wait write then immediate read of the same word: forwarding
    sel = 1'b0;
    addr_ph(1'b1, 3'd2, 32'h10, T_NSEQ);
    step();
    hwdata = 32'hDEADBEEF;
    addr_ph(1'b0, 3'd2, 32'h10, T_NSEQ);
    step();
    check("fwd_ready", {31'h0, ro_c}, 32'h1);
    check("fwd_resp", {31'h0, rs_c}, 32'h0);
    check("fwd_data", rd_c, 32'hDEADBEEF);
    bus_idle();
    step();

    // Byte write into lane 3 over an existing word
    do_write(32'h10, 3'd2, 32'h11223344);
    do_write(32'h13, 3'd0, 32'hAA5A5A5A);
    do_read(32'h10, r);
    check("byte_merge", r, 32'hAA223344);

    // Half write to upper lanes, read forwarded in the next cycle
    do_write(32'h14, 3'd2, 32'h0);
    addr_ph(1'b1, 3'd1, 32'h16, T_NSEQ);
    step();
    hwdata = 32'hBEEF1234;
    addr_ph(1'b0, 3'd2, 32'h14, T_NSEQ);
    step();
    check("half_fwd", rd_c, 32'hBEEF0000);
    bus_idle();
    step();

    // Back-to-back pipelined writes then reads, one beat per clock
    addr_ph(1'b1, 3'd2, 32'h40, T_NSEQ);
    hburst = 3'b011;
    step();
    for (int i = 0; i < 4; i++) begin
      hwdata = dat[i];
      if (i < 3) addr_ph(1'b1, 3'd2, 32'(32'h44 + 4 * i), T_SEQ);
      else       addr_ph(1'b0, 3'd2, 32'h40, T_NSEQ);
      check("b2b_wr_ready", {31'h0, ro_c}, 32'h1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check("b2b_rd_ready", {31'h0, ro_c}, 32'h1);
      check("b2b_rd_data", rd_c, dat[i]);
      if (i < 3) addr_ph(1'b0, 3'd2, 32'(32'h44 + 4 * i), T_SEQ);
      else       bus_idle();
      step();
    end
    hburst = 3'd0;

    // Capture held off while the bus is stalled by another slave
    stall = 1'b1;
    addr_ph(1'b1, 3'd2, 32'h50, T_NSEQ);
    step();
    check("stall_no_capture", {29'h0, st_c}, 32'h0);
    stall = 1'b0;
    step();
    check("stall_captured", {29'h0, st_c}, 32'h2);
    hwdata = 32'h50505050;
    bus_idle();
    step();
    do_read(32'h50, r);
    check("stall_data", r, 32'h50505050);

    // Misaligned word write: two-cycle ERROR, memory untouched
    do_write(32'h0, 3'd2, 32'hCAFEF00D);
    addr_ph(1'b1, 3'd2, 32'h02, T_NSEQ);
    step();
    check("mis_err1_ready", {31'h0, ro_c}, 32'h0);
    check("mis_err1_resp", {31'h0, rs_c}, 32'h1);
    hwdata = 32'hFFFFFFFF;
    bus_idle();
    step();
    check("mis_err2_ready", {31'h0, ro_c}, 32'h1);
    check("mis_err2_resp", {31'h0, rs_c}, 32'h1);
    step();
    check("mis_after_resp", {31'h0, rs_c}, 32'h0);
    do_read(32'h0, r);
    check("mis_unchanged", r, 32'hCAFEF00D);

    // Out-of-range read: two-cycle ERROR
    addr_ph(1'b0, 3'd2, 32'h1000, T_NSEQ);
    step();
    check("oor_err1_ready", {31'h0, ro_c}, 32'h0);
    check("oor_err1_resp", {31'h0, rs_c}, 32'h1);
    bus_idle();
    step();
    check("oor_err2_ready", {31'h0, ro_c}, 32'h1);
    check("oor_err2_resp", {31'h0, rs_c}, 32'h1);
    step();

    // Oversized transfer is also illegal
    addr_ph(1'b0, 3'd3, 32'h0, T_NSEQ);
    step();
    check("size3_resp", {31'h0, rs_c}, 32'h1);
    bus_idle();
    step(); step();

    // BUSY with HSEL=1 and NONSEQ with HSEL=0: OKAY, no write
    addr_ph(1'b1, 3'd2, 32'h10, T_BUSY);
    step();
    check("busy_ready", {31'h0, ro_c}, 32'h1);
    check("busy_resp", {31'h0, rs_c}, 32'h0);
    check("busy_state", {29'h0, st_c}, 32'h0);
    hwdata = 32'h0BAD0BAD;
    addr_ph(1'b1, 3'd2, 32'h10, T_NSEQ);
    hsel = 1'b0;
    step();
    hwdata = 32'h0BAD0BAD;
    bus_idle();
    step();
    do_read(32'h10, r);
    check("nosel_unchanged", r, 32'hAA223344);
    bus_idle();
    step();

    // Two-wait instance: INCR4 read from 0x20, 2 waits per beat, 12 cycles
    sel = 1'b1;
    for (int i = 0; i < 4; i++) do_write(32'(32'h20 + 4 * i), 3'd2, bdat[i]);
    addr_ph(1'b0, 3'd2, 32'h20, T_NSEQ);
    hburst = 3'b011;
    step();
    addr_ph(1'b0, 3'd2, 32'h24, T_SEQ);
    beat = 0; cyc = 0; waits = 0;
    while (beat < 4 && cyc < 40) begin
      if (ro_c) begin
        check("burst_data", rd_c, bdat[beat]);
        check("burst_waits", 32'(waits), 32'd2);
        beat++;
        waits = 0;
        step();
        cyc++;
        if (beat < 3) addr_ph(1'b0, 3'd2, 32'(32'h20 + 4 * (beat + 1)), T_SEQ);
        else          bus_idle();
      end else begin
        check("burst_wait_resp", {31'h0, rs_c}, 32'h0);
        waits++;
        step();
        cyc++;
      end
    end
    check("burst_beats", 32'(beat), 32'd4);
    check("burst_cycles", 32'(cyc), 32'd12);
    hburst = 3'd0;
    step();

    // Reset during the wait phase of a write abandons it
    do_write(32'h30, 3'd2, 32'h01020304);
    addr_ph(1'b1, 3'd2, 32'h30, T_NSEQ);
    step();
    check("rstw_in_wait", {29'h0, st_c}, 32'h1);
    check("rstw_wait_ready", {31'h0, ro_c}, 32'h0);
    hwdata = 32'hFFFFFFFF;
    bus_idle();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    check("rstw_ready", {31'h0, ro_c}, 32'h1);
    check("rstw_resp", {31'h0, rs_c}, 32'h0);
    check("rstw_state", {29'h0, st_c}, 32'h0);
    check("rstw_rdata", rd_c, 32'h0);
    do_read(32'h30, r);
    check("rstw_unchanged", r, 32'h01020304);
    bus_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
